blob_frame_sequencer: RTL
=========================

// Module: blob_frame_sequencer
// PURPOSE
// - Sequences one blob-count pass per frame: arms the blob counter and streams
//   exactly one binarized frame to it from the SDRAM read FIFO.
// - Waits for the counter's result, latches it, then returns the counter to idle.
// - Sits between the SDRAM read-side FIFO and the blob counter.
// - The blob counter cannot stall, so this block owns prefill, underrun and timeout handling.
// PARAMETERS
// - IMG_W       640     pixels per row
// - IMG_H       480     rows per frame; FRAME_PIX = IMG_W*IMG_H = 307200
// - FIFO_AW     10      FIFO level width; i_fifo_level is FIFO_AW+1 bits
// - PREFILL     512     minimum FIFO level before streaming starts
// - DONE_TMO    1024    max cycles in S_WAIT for i_blob_done after the last pixel
// PORTS
// - i_clk         in   1         clock
// - i_rst_n       in   1         asynchronous, active-low reset
// - i_start       in   1         single-pass request, level-sampled in S_IDLE
// - i_auto        in   1         1 = re-arm automatically after each pass
// - i_threshold   in   8         binarization threshold
// - i_pix_data    in   8         FIFO head pixel, grayscale
// - i_pix_valid   in   1         FIFO head valid (FIFO not empty)
// - i_fifo_level  in   FIFO_AW+1 FIFO occupancy
// - o_pix_rd      out  1         FIFO pop strobe
// - o_blob_valid  out  1         drives blob counter i_valid
// - o_blob_seq    out  1         binarized pixel to blob counter i_seq
// - i_blob_done   in   1         blob counter o_valid
// - i_blob_count  in   8         blob counter o_count
// - o_count       out  8         last latched blob count
// - o_count_valid out  1         1-cycle pulse when o_count updates
// - o_busy        out  1         high in every state except S_IDLE
// - o_underrun    out  1         sticky per pass; at least one pixel substituted
// - o_timeout     out  1         1-cycle pulse; pass aborted in S_WAIT
// BEHAVIOUR
// - Reset: state S_IDLE; all outputs 0; pixel counter 0; timeout counter 0.
//   Reset mid-pass aborts immediately; o_count returns to 0.
// - All outputs are registered. Pixel counter is 19 bits; timeout counter is 11 bits.
// - S_IDLE: if i_start|i_auto -> S_PREFILL. Clear o_underrun on that transition.
// - S_PREFILL: when i_fifo_level >= PREFILL -> S_ARM.
// - S_ARM: o_blob_valid=1 for one cycle (counter enters PROC) -> S_STREAM.
// - S_STREAM: o_blob_valid=1 held.
//   - Every cycle: o_pix_rd=i_pix_valid and o_blob_seq=i_pix_valid&&(i_pix_data>=i_threshold).
//   - o_blob_seq is registered, 1-cycle latency from the FIFO head.
//   - Exactly FRAME_PIX cycles, one pixel per cycle, no stall.
//   - If i_pix_valid=0: emit seq=0, no pop, set o_underrun. The cycle still counts.
//   - After cycle FRAME_PIX-1 -> S_WAIT; timeout counter cleared.
// - S_WAIT: o_blob_valid=1, o_pix_rd=0.
//   - On i_blob_done: latch o_count=i_blob_count, pulse o_count_valid -> S_RELEASE.
//   - On timeout counter reaching DONE_TMO-1: pulse o_timeout, o_count unchanged -> S_RELEASE.
// - S_RELEASE: o_blob_valid=0.
//   - Stay until i_blob_done=0 (counter back in IDLE); minimum 1 cycle.
//   - Then -> S_PREFILL if i_auto, else S_IDLE.
// - i_start is ignored while o_busy=1 (no queueing).
// - i_auto deasserted mid-pass: the current pass completes, then -> S_IDLE.
// - i_threshold is sampled every pixel; changes mid-frame take effect on the next pixel.
// - Simultaneous i_blob_done and timeout in the same cycle: done wins, no o_timeout.
// - i_fifo_level > PREFILL: accepted. PREFILL is compared with >=, never ==.
// TESTING
// - Reset, then i_start=1 with level>=PREFILL and all pixels 0xFF, thr 0x80:
//   o_blob_valid rises 2 cycles after start; 307200 pops; seq=1 throughout.
// - Model i_blob_done=1, i_blob_count=8'd5 three cycles after stream end:
//   o_count=5, single o_count_valid pulse, o_blob_valid=0 next cycle.
// - Drop i_pix_valid for 10 cycles mid-stream:
//   o_underrun=1; exactly 307200 stream cycles; 307190 pops.
// - Hold i_blob_done=0 after the stream: o_timeout pulses at cycle 1024 of S_WAIT;
//   o_count keeps its previous value; returns to S_IDLE.
// - i_auto=1 for 3 passes returning counts 1/2/3: o_count sequence 1,2,3.
//   Clear i_auto during pass 3: S_IDLE after its release.
// - Assert i_rst_n=0 at pixel 1000: all outputs 0 asynchronously; new i_start gives a clean pass.

Source files
------------

// File: rtl/blob_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blob_frame_sequencer: streams one binarized frame per pass from the SDRAM |
// | read FIFO into the blob counter and latches its result.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module blob_frame_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int FIFO_AW  = 10,
  parameter int PREFILL  = 512,
  parameter int DONE_TMO = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_auto,
  input  logic [7:0]       i_threshold,
  input  logic [7:0]       i_pix_data,
  input  logic             i_pix_valid,
  input  logic [FIFO_AW:0] i_fifo_level,
  output logic             o_pix_rd,
  output logic             o_blob_valid,
  output logic             o_blob_seq,
  input  logic             i_blob_done,
  input  logic [7:0]       i_blob_count,
  output logic [7:0]       o_count,
  output logic             o_count_valid,
  output logic             o_busy,
  output logic             o_underrun,
  output logic             o_timeout
);

  localparam int               c_LAST_PIX_I  = IMG_W * IMG_H - 1;
  localparam int               c_LAST_TMO_I  = DONE_TMO - 1;
  localparam logic [18:0]      c_LAST_PIX    = c_LAST_PIX_I[18:0];
  localparam logic [10:0]      c_LAST_TMO    = c_LAST_TMO_I[10:0];
  localparam logic [FIFO_AW:0] c_PREFILL_LVL = PREFILL[FIFO_AW:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARM     = 3'd2,
    S_STREAM  = 3'd3,
    S_WAIT    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t      r_state;
  logic [18:0] r_pix_cnt;
  logic [10:0] r_tmo_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pix_cnt     <= '0;
      r_tmo_cnt     <= '0;
      o_pix_rd      <= 1'b0;
      o_blob_valid  <= 1'b0;
      o_blob_seq    <= 1'b0;
      o_count       <= '0;
      o_count_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_underrun    <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_pix_rd      <= 1'b0;
      o_blob_seq    <= 1'b0;
      o_count_valid <= 1'b0;
      o_timeout     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start || i_auto) begin
            r_state    <= S_PREFILL;
            o_busy     <= 1'b1;
            o_underrun <= 1'b0;
          end
        end
        S_PREFILL: begin
          if (i_fifo_level >= c_PREFILL_LVL) begin
            r_state      <= S_ARM;
            o_blob_valid <= 1'b1;
          end
        end
        S_ARM: begin
          r_state   <= S_STREAM;
          r_pix_cnt <= '0;
        end
        S_STREAM: begin
          // The counter cannot stall: an empty FIFO still consumes a pixel slot as background.
          o_pix_rd   <= i_pix_valid;
          o_blob_seq <= i_pix_valid && (i_pix_data >= i_threshold);
          if (!i_pix_valid) o_underrun <= 1'b1;
          if (r_pix_cnt == c_LAST_PIX) begin
            r_state   <= S_WAIT;
            r_pix_cnt <= '0;
            r_tmo_cnt <= '0;
          end else begin
            r_pix_cnt <= r_pix_cnt + 19'd1;
          end
        end
        S_WAIT: begin
          if (i_blob_done) begin
            o_count       <= i_blob_count;
            o_count_valid <= 1'b1;
            o_blob_valid  <= 1'b0;
            r_state       <= S_RELEASE;
          end else if (r_tmo_cnt == c_LAST_TMO) begin
            o_timeout    <= 1'b1;
            o_blob_valid <= 1'b0;
            r_state      <= S_RELEASE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 11'd1;
          end
        end
        S_RELEASE: begin
          // Counter drops done once it has seen valid low and returned to idle.
          if (!i_blob_done) begin
            if (i_auto) begin
              r_state    <= S_PREFILL;
              o_underrun <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          o_busy       <= 1'b0;
          o_blob_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
